// File: rtl/fetch_defs_pkg.sv
// Shared widths, reset vector and sequencer state encodings for the fetch unit.
package fetch_defs;

   localparam int ADDR_W = 16;
   localparam int INST_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef enum logic {
      FS_RUN    = 1'b0,
      FS_HALTED = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order buffer between instruction memory and decode.
// Slot 0 is always the head; flush wins over a simultaneous push.
module fetch_skid_buffer
   import fetch_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_flush,
   input  logic [ADDR_W-1:0] i_push_pc,
   input  logic [INST_W-1:0] i_push_inst,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_pc,
   output logic [INST_W-1:0] o_inst,
   output logic [1:0]        o_occ
);

   logic [ADDR_W-1:0] r_pc0;
   logic [ADDR_W-1:0] r_pc1;
   logic [INST_W-1:0] r_inst0;
   logic [INST_W-1:0] r_inst1;
   logic [1:0]        r_occ;
   logic              w_pop;

   assign w_pop   = i_pop & (r_occ != 2'd0);
   assign o_valid = (r_occ != 2'd0);
   assign o_pc    = r_pc0;
   assign o_inst  = r_inst0;
   assign o_occ   = r_occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc0   <= '0;
         r_pc1   <= '0;
         r_inst0 <= '0;
         r_inst1 <= '0;
         r_occ   <= 2'd0;
      end else if (i_flush) begin
         r_occ <= 2'd0;
      end else begin
         case (r_occ)
            2'd0: begin
               if (i_push) begin
                  r_pc0   <= i_push_pc;
                  r_inst0 <= i_push_inst;
                  r_occ   <= 2'd1;
               end
            end
            2'd1: begin
               if (i_push && w_pop) begin
                  r_pc0   <= i_push_pc;
                  r_inst0 <= i_push_inst;
               end else if (i_push) begin
                  r_pc1   <= i_push_pc;
                  r_inst1 <= i_push_inst;
                  r_occ   <= 2'd2;
               end else if (w_pop) begin
                  r_occ <= 2'd0;
               end
            end
            2'd2: begin
               // A push into a full buffer cannot happen unless a pop frees the tail.
               if (w_pop) begin
                  r_pc0   <= r_pc1;
                  r_inst0 <= r_inst1;
                  if (i_push) begin
                     r_pc1   <= i_push_pc;
                     r_inst1 <= i_push_inst;
                  end else begin
                     r_occ <= 2'd1;
                  end
               end
            end
            default: r_occ <= 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, tracks the one-cycle memory
// latency, applies redirects and halt, and feeds decode through a skid buffer.
module fetch_unit
   import fetch_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_a,
   input  logic [INST_W-1:0] imem_rd,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              halted
);

   fetch_state_e      r_state;
   fetch_state_e      w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_tag;
   logic              r_inflight;
   logic [1:0]        w_occ;
   logic              w_pop;
   logic              w_issue;
   logic [2:0]        w_credit;

   assign imem_a = r_pc;
   assign w_pop  = inst_valid & inst_ready;

   // Words already owed to decode after this cycle's pop; at most two may be outstanding.
   assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue  = (r_state == FS_RUN) & ~halt & ~redirect_valid & (w_credit < 3'd2);
   assign halted   = halt & ~r_inflight & (w_occ == 2'd0);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         FS_RUN:    if (halt && !r_inflight && (w_occ == 2'd0)) w_next_state = FS_HALTED;
         FS_HALTED: if (!halt) w_next_state = FS_RUN;
         default:   w_next_state = FS_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FS_RUN;
         r_pc       <= RESET_PC;
         r_tag      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
         end else if (w_issue) begin
            r_pc       <= r_pc + 1'b1;
            r_tag      <= r_pc;
            r_inflight <= 1'b1;
         end else begin
            r_inflight <= 1'b0;
         end
      end
   end

   fetch_skid_buffer u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (r_inflight),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .i_push_pc   (r_tag),
      .i_push_inst (imem_rd),
      .o_valid     (inst_valid),
      .o_pc        (inst_pc),
      .o_inst      (inst),
      .o_occ       (w_occ)
   );

endmodule
